// File: rtl/emg_sar_conv_ctrl.sv
// SAR conversion controller for the EMG front-end ADC.
// The controller samples the input and then runs a binary search on the
// capacitive DAC, using one comparator decision per clock.
// Each result is tagged with its channel number and stored in a small FIFO.
// A valid/ready handshake on the FIFO output feeds the EMG data packer.
module emg_sar_conv_ctrl #(
  parameter int RES_BITS      = 10,
  parameter int SAMPLE_CYCLES = 2,
  parameter int CH_BITS       = 4,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                CLK_EMG,
  input  logic                RESET,
  input  logic                EN_ADC,
  input  logic                START,
  input  logic [CH_BITS-1:0]  CH_SEL,
  input  logic                COMP,
  output logic                SAMPLE_EMG,
  output logic [RES_BITS-1:0] DAC_CODE,
  output logic                BUSY,
  output logic                EOC,
  output logic [RES_BITS-1:0] DOUT,
  output logic [CH_BITS-1:0]  DOUT_CH,
  output logic                DOUT_VALID,
  input  logic                DOUT_READY,
  output logic                OVERFLOW,
  output logic                START_MISS
);

  localparam int SAMP_W = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int ENT_W  = CH_BITS + RES_BITS;

  localparam logic [SAMP_W-1:0]   SAMP_LAST  = SAMP_W'(SAMPLE_CYCLES - 1);
  localparam logic [RES_BITS-1:0] DAC_MSB    = RES_BITS'(1) << (RES_BITS - 1);
  localparam logic [CNT_W-1:0]    FIFO_FULLC = CNT_W'(FIFO_DEPTH);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SAMPLE  = 2'd1;
  localparam logic [1:0] ST_CONVERT = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  logic [1:0]          state;
  logic [SAMP_W-1:0]   samp_cnt;
  logic [RES_BITS-1:0] trial_mask;
  logic [CH_BITS-1:0]  ch_tag;
  logic [RES_BITS-1:0] resolved;

  logic [ENT_W-1:0]    fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [CNT_W-1:0]    fifo_cnt;

  logic                push_req;
  logic                do_push;
  logic                do_pop;
  logic                fifo_full;
  logic [ENT_W-1:0]    push_data;
  logic [PTR_W-1:0]    rd_next;
  logic [CNT_W-1:0]    cnt_next;
  logic [CNT_W-1:0]    cnt_kept;

  // Current trial code with the bit under test cleared if the comparator rejected it.
  assign resolved  = COMP ? DAC_CODE : (DAC_CODE & ~trial_mask);

  // A finished conversion is handed to the FIFO as it leaves DONE, unless it is being aborted.
  assign push_req  = (state == ST_DONE) && EN_ADC;
  assign push_data = {ch_tag, DAC_CODE};
  assign fifo_full = (fifo_cnt == FIFO_FULLC);
  assign do_pop    = DOUT_VALID && DOUT_READY;
  assign do_push   = push_req && (!fifo_full || do_pop);
  assign cnt_kept  = fifo_cnt - CNT_W'(do_pop);
  assign cnt_next  = cnt_kept + CNT_W'(do_push);
  assign rd_next   = rd_ptr + PTR_W'(do_pop);

  // Conversion sequencer: sample phase, one SAR bit per clock, then hand-off.
  always_ff @(posedge CLK_EMG) begin
    if (RESET) begin
      state      <= ST_IDLE;
      samp_cnt   <= '0;
      trial_mask <= '0;
      ch_tag     <= '0;
      SAMPLE_EMG <= 1'b0;
      DAC_CODE   <= '0;
      BUSY       <= 1'b0;
      EOC        <= 1'b0;
      START_MISS <= 1'b0;
    end else begin
      if (START && BUSY) begin
        START_MISS <= 1'b1;
      end
      if (state == ST_IDLE) begin
        if (START && EN_ADC) begin
          state      <= ST_SAMPLE;
          ch_tag     <= CH_SEL;
          samp_cnt   <= '0;
          SAMPLE_EMG <= 1'b1;
          BUSY       <= 1'b1;
          DAC_CODE   <= '0;
        end
      end else if (!EN_ADC) begin
        state      <= ST_IDLE;
        trial_mask <= '0;
        SAMPLE_EMG <= 1'b0;
        DAC_CODE   <= '0;
        BUSY       <= 1'b0;
        EOC        <= 1'b0;
      end else begin
        case (state)
          ST_SAMPLE: begin
            if (samp_cnt == SAMP_LAST) begin
              state      <= ST_CONVERT;
              SAMPLE_EMG <= 1'b0;
              DAC_CODE   <= DAC_MSB;
              trial_mask <= DAC_MSB;
            end else begin
              samp_cnt <= samp_cnt + 1'b1;
            end
          end
          ST_CONVERT: begin
            if (trial_mask[0]) begin
              state    <= ST_DONE;
              DAC_CODE <= resolved;
              EOC      <= 1'b1;
            end else begin
              DAC_CODE   <= resolved | (trial_mask >> 1);
              trial_mask <= trial_mask >> 1;
            end
          end
          ST_DONE: begin
            state <= ST_IDLE;
            BUSY  <= 1'b0;
            EOC   <= 1'b0;
          end
          default: begin
            state      <= ST_IDLE;
            SAMPLE_EMG <= 1'b0;
            DAC_CODE   <= '0;
            BUSY       <= 1'b0;
            EOC        <= 1'b0;
          end
        endcase
      end
    end
  end

  // Result FIFO with a registered head. A push into an empty FIFO loads the head directly.
  always_ff @(posedge CLK_EMG) begin
    if (RESET) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_cnt   <= '0;
      DOUT       <= '0;
      DOUT_CH    <= '0;
      DOUT_VALID <= 1'b0;
      OVERFLOW   <= 1'b0;
    end else begin
      if (do_push) begin
        fifo_mem[wr_ptr] <= push_data;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      rd_ptr     <= rd_next;
      fifo_cnt   <= cnt_next;
      DOUT_VALID <= (cnt_next != '0);
      if (cnt_next != '0) begin
        if (cnt_kept == '0) begin
          {DOUT_CH, DOUT} <= push_data;
        end else begin
          {DOUT_CH, DOUT} <= fifo_mem[rd_next];
        end
      end
      if (push_req && fifo_full && !do_pop) begin
        OVERFLOW <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_emg_sar_conv_ctrl.sv
// Directed testbench for emg_sar_conv_ctrl using the default parameters.
// The comparator is modelled as an ideal analog input code "vin"
// compared against the DAC trial code.
module tb_emg_sar_conv_ctrl;

  logic       CLK_EMG = 1'b0;
  logic       RESET = 1'b1;
  logic       EN_ADC = 1'b0;
  logic       START = 1'b0;
  logic [3:0] CH_SEL = 4'd0;
  logic       COMP;
  logic       SAMPLE_EMG;
  logic [9:0] DAC_CODE;
  logic       BUSY;
  logic       EOC;
  logic [9:0] DOUT;
  logic [3:0] DOUT_CH;
  logic       DOUT_VALID;
  logic       DOUT_READY = 1'b0;
  logic       OVERFLOW;
  logic       START_MISS;

  logic [9:0] vin = 10'd0;
  int checks = 0;
  int errors = 0;

  emg_sar_conv_ctrl dut (
    .CLK_EMG(CLK_EMG), .RESET(RESET), .EN_ADC(EN_ADC), .START(START),
    .CH_SEL(CH_SEL), .COMP(COMP), .SAMPLE_EMG(SAMPLE_EMG), .DAC_CODE(DAC_CODE),
    .BUSY(BUSY), .EOC(EOC), .DOUT(DOUT), .DOUT_CH(DOUT_CH),
    .DOUT_VALID(DOUT_VALID), .DOUT_READY(DOUT_READY),
    .OVERFLOW(OVERFLOW), .START_MISS(START_MISS)
  );

  // Ideal comparator: asserts when the input is at or above the DAC trial level.
  assign COMP = (vin >= DAC_CODE);

  // 100 MHz conversion clock.
  always #5 CLK_EMG = ~CLK_EMG;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge CLK_EMG);
    #1;
  endtask

  // Count one comparison and report it if the observed value differs from the expected one.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Pulse START for one edge on the given channel. On return, edge E0 has just passed.
  task automatic applyStimulus(input logic [3:0] ch);
    CH_SEL = ch;
    START  = 1'b1;
    tick();
    START  = 1'b0;
  endtask

  // Run a full conversion. On return, edge E13 (the push edge) has just passed.
  task automatic convertOnce(input logic [9:0] v, input logic [3:0] ch);
    vin = v;
    applyStimulus(ch);
    repeat (13) tick();
  endtask

  // Check every output against its reset value.
  task automatic checkAllZero(input string tag);
    checkOutput({tag, " SAMPLE_EMG"}, 32'(SAMPLE_EMG), 0);
    checkOutput({tag, " DAC_CODE"},   32'(DAC_CODE),   0);
    checkOutput({tag, " BUSY"},       32'(BUSY),       0);
    checkOutput({tag, " EOC"},        32'(EOC),        0);
    checkOutput({tag, " DOUT"},       32'(DOUT),       0);
    checkOutput({tag, " DOUT_CH"},    32'(DOUT_CH),    0);
    checkOutput({tag, " DOUT_VALID"}, 32'(DOUT_VALID), 0);
    checkOutput({tag, " OVERFLOW"},   32'(OVERFLOW),   0);
    checkOutput({tag, " START_MISS"}, 32'(START_MISS), 0);
  endtask

  logic [9:0] resolvedModel;
  logic [9:0] trialModel;
  logic [9:0] fillVals [5];
  int sawEoc;
  int sawValid;

  initial begin
    // Reset state.
    RESET = 1'b1;
    tick();
    tick();
    RESET = 1'b0;
    checkAllZero("reset");

    // Test 1: single conversion of 0x2A5 on channel 5, with the DAC trial sequence checked.
    EN_ADC = 1'b1;
    DOUT_READY = 1'b1;
    vin = 10'h2A5;
    applyStimulus(4'd5);
    checkOutput("t1 E0 SAMPLE_EMG", 32'(SAMPLE_EMG), 1);
    checkOutput("t1 E0 BUSY", 32'(BUSY), 1);
    checkOutput("t1 E0 DAC_CODE", 32'(DAC_CODE), 0);
    tick();
    checkOutput("t1 E1 SAMPLE_EMG", 32'(SAMPLE_EMG), 1);
    tick();
    checkOutput("t1 E2 SAMPLE_EMG", 32'(SAMPLE_EMG), 0);
    resolvedModel = 10'h000;
    for (int k = 9; k >= 0; k--) begin
      trialModel = resolvedModel | (10'h001 << k);
      checkOutput($sformatf("t1 trial bit%0d", k), 32'(DAC_CODE), 32'(trialModel));
      checkOutput($sformatf("t1 EOC low bit%0d", k), 32'(EOC), 0);
      tick();
      if (vin >= trialModel) resolvedModel = trialModel;
    end
    checkOutput("t1 E12 DAC_CODE", 32'(DAC_CODE), 32'h2A5);
    checkOutput("t1 E12 EOC", 32'(EOC), 1);
    checkOutput("t1 E12 BUSY", 32'(BUSY), 1);
    checkOutput("t1 E12 DOUT_VALID", 32'(DOUT_VALID), 0);
    tick();
    checkOutput("t1 E13 EOC", 32'(EOC), 0);
    checkOutput("t1 E13 BUSY", 32'(BUSY), 0);
    checkOutput("t1 E13 DOUT_VALID", 32'(DOUT_VALID), 1);
    checkOutput("t1 E13 DOUT", 32'(DOUT), 32'h2A5);
    checkOutput("t1 E13 DOUT_CH", 32'(DOUT_CH), 5);
    tick();
    checkOutput("t1 E14 popped", 32'(DOUT_VALID), 0);

    // Test 2: extreme inputs, giving all-zero and all-one comparator sequences.
    convertOnce(10'h000, 4'd2);
    checkOutput("t2 zero DOUT", 32'(DOUT), 32'h000);
    checkOutput("t2 zero DOUT_CH", 32'(DOUT_CH), 2);
    convertOnce(10'h3FF, 4'd3);
    checkOutput("t2 full DOUT", 32'(DOUT), 32'h3FF);
    checkOutput("t2 full DOUT_CH", 32'(DOUT_CH), 3);

    // Test 3: back-to-back sweep with a START every 14 cycles, 16 channels plus wrap to 0.
    for (int i = 0; i < 17; i++) begin
      convertOnce(10'((i * 61 + 7) & 32'h3FF), 4'(i));
      checkOutput($sformatf("t3 conv%0d DOUT", i), 32'(DOUT), (i * 61 + 7) & 32'h3FF);
      checkOutput($sformatf("t3 conv%0d DOUT_CH", i), 32'(DOUT_CH), i & 15);
    end
    checkOutput("t3 START_MISS", 32'(START_MISS), 0);

    // Test 4: an extra START at E5 is ignored and flagged.
    vin = 10'h155;
    applyStimulus(4'd7);
    repeat (4) tick();
    START = 1'b1;
    tick();
    START = 1'b0;
    repeat (8) tick();
    checkOutput("t4 START_MISS", 32'(START_MISS), 1);
    checkOutput("t4 DOUT", 32'(DOUT), 32'h155);
    checkOutput("t4 DOUT_CH", 32'(DOUT_CH), 7);
    tick();
    checkOutput("t4 no restart BUSY", 32'(BUSY), 0);

    // Test 5: dropping EN_ADC at E7 aborts without EOC or a FIFO entry.
    vin = 10'h0F0;
    applyStimulus(4'd9);
    repeat (6) tick();
    EN_ADC = 1'b0;
    tick();
    checkOutput("t5 abort BUSY", 32'(BUSY), 0);
    checkOutput("t5 abort DAC_CODE", 32'(DAC_CODE), 0);
    checkOutput("t5 abort SAMPLE_EMG", 32'(SAMPLE_EMG), 0);
    checkOutput("t5 abort EOC", 32'(EOC), 0);
    EN_ADC = 1'b1;
    sawEoc = 0;
    sawValid = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (EOC) sawEoc++;
      if (DOUT_VALID) sawValid++;
    end
    checkOutput("t5 no EOC after abort", 32'(sawEoc), 0);
    checkOutput("t5 no entry after abort", 32'(sawValid), 0);
    convertOnce(10'h0F0, 4'd9);
    checkOutput("t5 next DOUT", 32'(DOUT), 32'h0F0);
    checkOutput("t5 next DOUT_CH", 32'(DOUT_CH), 9);
    tick();
    checkOutput("t6 FIFO empty start", 32'(DOUT_VALID), 0);

    // Test 6: backpressure fills the FIFO, the fifth result overflows.
    DOUT_READY = 1'b0;
    fillVals[0] = 10'h011; fillVals[1] = 10'h122; fillVals[2] = 10'h233;
    fillVals[3] = 10'h344; fillVals[4] = 10'h0AB;
    for (int i = 0; i < 4; i++) convertOnce(fillVals[i], 4'(10 + i));
    checkOutput("t6 four held OVERFLOW", 32'(OVERFLOW), 0);
    checkOutput("t6 head stable DOUT", 32'(DOUT), 32'h011);
    convertOnce(fillVals[4], 4'd14);
    checkOutput("t6 OVERFLOW", 32'(OVERFLOW), 1);
    checkOutput("t6 head DOUT", 32'(DOUT), 32'h011);
    checkOutput("t6 head DOUT_CH", 32'(DOUT_CH), 10);

    // Push and pop on the same edge while full: nothing is lost.
    vin = 10'h2C7;
    applyStimulus(4'd15);
    repeat (12) tick();
    DOUT_READY = 1'b1;
    tick();
    for (int i = 1; i < 4; i++) begin
      checkOutput($sformatf("t6 drain%0d DOUT", i), 32'(DOUT), 32'(fillVals[i]));
      checkOutput($sformatf("t6 drain%0d DOUT_CH", i), 32'(DOUT_CH), 10 + i);
      tick();
    end
    checkOutput("t6 drain last DOUT", 32'(DOUT), 32'h2C7);
    checkOutput("t6 drain last DOUT_CH", 32'(DOUT_CH), 15);
    tick();
    checkOutput("t6 drained", 32'(DOUT_VALID), 0);

    // Synchronous reset in the middle of CONVERT, with a FIFO entry waiting.
    DOUT_READY = 1'b0;
    convertOnce(10'h123, 4'd1);
    checkOutput("t6 pre-reset valid", 32'(DOUT_VALID), 1);
    vin = 10'h321;
    applyStimulus(4'd2);
    repeat (5) tick();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    checkAllZero("t6 mid reset");
    repeat (3) tick();
    checkOutput("t6 post reset BUSY", 32'(BUSY), 0);
    checkOutput("t6 post reset DOUT_VALID", 32'(DOUT_VALID), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
